// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: assembles CMD/DATA/CHK frames and drives acks.
// Bad frames, timeouts and aborts report an error code and are counted.
module spi_cmd_decoder #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
  parameter logic [15:0] MAX_IP         = 16'd78,
  parameter logic [15:0] TON_RESET      = 16'd10,
  parameter logic [15:0] TOFF_RESET     = 16'd50,
  parameter logic [15:0] IP_RESET       = 16'd20,
  parameter logic [15:0] WAVEFORM_RESET = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        rx_valid,
  input  logic [15:0] rx_word,
  output logic        machine_start_ack_spi,
  output logic        machine_stop_ack_spi,
  output logic        change_Ton_ack,
  output logic [15:0] Ton_data_async,
  output logic        change_Toff_ack,
  output logic [15:0] Toff_data_async,
  output logic        change_Ip_ack,
  output logic [15:0] Ip_data_async,
  output logic        change_waveform_ack,
  output logic [15:0] waveform_data_async,
  output logic        tx_load,
  output logic [15:0] tx_word,
  output logic        frame_error,
  output logic [7:0]  error_count
);

  typedef enum logic [1:0] {
    IDLE,
    GOT_CMD,
    GOT_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic [15:0] cnt_q, cnt_d;

  logic accept, busy, abort, tmo, chk_ev;
  logic is_start, is_stop, is_ton;
  logic is_toff, is_ip, is_wave;
  logic known, sum_ok, range_ok, ok;
  logic ton_ok, toff_ok, ip_ok, wave_ok;
  logic [2:0] err_code;

  assign accept = rx_valid & ~cs_n;
  assign busy   = (state_q != IDLE);
  assign abort  = busy & cs_n;
  assign tmo    = busy & ~accept &
                  (cnt_q == TIMEOUT_CYCLES);
  assign chk_ev = (state_q == GOT_DATA) & accept;

  assign is_start = (cmd_q == 16'hA001);
  assign is_stop  = (cmd_q == 16'hA002);
  assign is_ton   = (cmd_q == 16'hA010);
  assign is_toff  = (cmd_q == 16'hA011);
  assign is_ip    = (cmd_q == 16'hA012);
  assign is_wave  = (cmd_q == 16'hA013);
  assign known    = is_start | is_stop | is_ton |
                    is_toff | is_ip | is_wave;

  assign sum_ok  = (rx_word == (cmd_q ^ data_q));
  assign ton_ok  = (data_q >= 16'd1) &&
                   (data_q <= 16'd1000);
  assign toff_ok = (data_q >= 16'd1) &&
                   (data_q <= 16'd10000);
  assign ip_ok   = (data_q >= 16'd1) &&
                   (data_q <= MAX_IP);
  assign wave_ok = (data_q == 16'h8000) ||
                   (data_q == 16'h0001) ||
                   (data_q == 16'h0002);

  assign range_ok = !(is_ton  && !ton_ok)  &&
                    !(is_toff && !toff_ok) &&
                    !(is_ip   && !ip_ok)   &&
                    !(is_wave && !wave_ok);

  // Lowest applicable code wins.
  always_comb begin
    err_code = 3'd0;
    if (chk_ev) begin
      if (!known)         err_code = 3'd1;
      else if (!sum_ok)   err_code = 3'd2;
      else if (!range_ok) err_code = 3'd3;
    end else if (tmo) begin
      err_code = 3'd4;
    end else if (abort) begin
      err_code = 3'd5;
    end
  end

  assign ok = chk_ev & (err_code == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          cmd_d   = rx_word;
          state_d = GOT_CMD;
        end
      end
      GOT_CMD, GOT_DATA: begin
        if (accept) begin
          cnt_d = '0;
          if (state_q == GOT_CMD) begin
            data_d  = rx_word;
            state_d = GOT_DATA;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo || abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      machine_start_ack_spi <= 1'b0;
      machine_stop_ack_spi  <= 1'b0;
      change_Ton_ack        <= 1'b0;
      change_Toff_ack       <= 1'b0;
      change_Ip_ack         <= 1'b0;
      change_waveform_ack   <= 1'b0;
      Ton_data_async        <= TON_RESET;
      Toff_data_async       <= TOFF_RESET;
      Ip_data_async         <= IP_RESET;
      waveform_data_async   <= WAVEFORM_RESET;
      tx_load               <= 1'b0;
      tx_word               <= '0;
      frame_error           <= 1'b0;
      error_count           <= '0;
    end else begin
      machine_start_ack_spi <= 1'b0;
      machine_stop_ack_spi  <= 1'b0;
      change_Ton_ack        <= 1'b0;
      change_Toff_ack       <= 1'b0;
      change_Ip_ack         <= 1'b0;
      change_waveform_ack   <= 1'b0;
      tx_load               <= 1'b0;
      frame_error           <= 1'b0;
      if (ok) begin
        tx_load <= 1'b1;
        tx_word <= {8'h5A, cmd_q[7:0]};
        unique case (1'b1)
          is_start: machine_start_ack_spi <= 1'b1;
          is_stop:  machine_stop_ack_spi  <= 1'b1;
          is_ton: begin
            change_Ton_ack <= 1'b1;
            Ton_data_async <= data_q;
          end
          is_toff: begin
            change_Toff_ack <= 1'b1;
            Toff_data_async <= data_q;
          end
          is_ip: begin
            change_Ip_ack <= 1'b1;
            Ip_data_async <= data_q;
          end
          is_wave: begin
            change_waveform_ack <= 1'b1;
            waveform_data_async <= data_q;
          end
        endcase
      end else if (err_code != 3'd0) begin
        tx_load     <= 1'b1;
        tx_word     <= {13'h1C00, err_code};
        frame_error <= 1'b1;
        if (error_count != 8'hFF)
          error_count <= error_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: vector table, random frames vs model,
// and directed timeout/abort/saturation/reset sequences.
module tb_spi_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic        rx_valid;
  logic [15:0] rx_word;
  logic        start_ack, stop_ack;
  logic        ton_ack, toff_ack, ip_ack, wave_ack;
  logic [15:0] ton_d, toff_d, ip_d, wave_d;
  logic        tx_load;
  logic [15:0] tx_word;
  logic        frame_error;
  logic [7:0]  error_count;
  logic [5:0]  acks;

  assign acks = {start_ack, stop_ack, ton_ack,
                 toff_ack, ip_ack, wave_ack};

  always #5 clk = ~clk;

  spi_cmd_decoder dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cs_n                  (cs_n),
    .rx_valid              (rx_valid),
    .rx_word               (rx_word),
    .machine_start_ack_spi (start_ack),
    .machine_stop_ack_spi  (stop_ack),
    .change_Ton_ack        (ton_ack),
    .Ton_data_async        (ton_d),
    .change_Toff_ack       (toff_ack),
    .Toff_data_async       (toff_d),
    .change_Ip_ack         (ip_ack),
    .Ip_data_async         (ip_d),
    .change_waveform_ack   (wave_ack),
    .waveform_data_async   (wave_d),
    .tx_load               (tx_load),
    .tx_word               (tx_word),
    .frame_error           (frame_error),
    .error_count           (error_count)
  );

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] data;
    logic [15:0] chk;
    logic [15:0] exp_tx;
    logic [5:0]  exp_ack;
  } vec_t;

  vec_t vec[16];

  int tests = 0;
  int fails = 0;

  logic [15:0] m_ton, m_toff, m_ip, m_wave;
  int          m_err;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ton  = 16'd10;
    m_toff = 16'd50;
    m_ip   = 16'd20;
    m_wave = 16'h0001;
    m_err  = 0;
  endtask

  function automatic int code_of(input logic [15:0] c,
                                 input logic [15:0] d,
                                 input logic [15:0] k);
    if (!(c inside {16'hA001, 16'hA002, 16'hA010,
                    16'hA011, 16'hA012, 16'hA013}))
      return 1;
    if (k != (c ^ d)) return 2;
    if (c == 16'hA010 && (d < 1 || d > 1000)) return 3;
    if (c == 16'hA011 && (d < 1 || d > 10000)) return 3;
    if (c == 16'hA012 && (d < 1 || d > 78)) return 3;
    if (c == 16'hA013 &&
        !(d inside {16'h8000, 16'h0001, 16'h0002}))
      return 3;
    return 0;
  endfunction

  task automatic model_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_apply(input logic [15:0] c,
                             input logic [15:0] d,
                             input logic [15:0] k,
                             output logic [15:0] tx,
                             output logic [5:0] ack);
    int code;
    code = code_of(c, d, k);
    ack  = 6'b0;
    if (code == 0) begin
      tx = 16'h5A00 | (c & 16'h00FF);
      case (c)
        16'hA001: ack = 6'b100000;
        16'hA002: ack = 6'b010000;
        16'hA010: begin ack = 6'b001000; m_ton = d; end
        16'hA011: begin ack = 6'b000100; m_toff = d; end
        16'hA012: begin ack = 6'b000010; m_ip = d; end
        default:  begin ack = 6'b000001; m_wave = d; end
      endcase
    end else begin
      tx = 16'hE000 | 16'(code);
      model_err();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [15:0] w);
    rx_valid = 1'b1;
    rx_word  = w;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check_state(input string name);
    check({name, " ton"},  ton_d,  m_ton);
    check({name, " toff"}, toff_d, m_toff);
    check({name, " ip"},   ip_d,   m_ip);
    check({name, " wave"}, wave_d, m_wave);
    check({name, " errcnt"}, error_count, m_err);
  endtask

  task automatic check_resp(input string name,
                            input logic [15:0] tx,
                            input logic [5:0] ack);
    check({name, " tx_load"}, tx_load, 1'b1);
    check({name, " tx_word"}, tx_word, tx);
    check({name, " acks"}, acks, ack);
    check({name, " frame_error"}, frame_error,
          tx[15:12] == 4'hE);
    check_state(name);
  endtask

  task automatic run_frame(input string name,
                           input logic [15:0] c,
                           input logic [15:0] d,
                           input logic [15:0] k,
                           input logic [15:0] tx,
                           input logic [5:0] ack);
    put_word(c);
    put_word(d);
    put_word(k);
    check_resp(name, tx, ack);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] tx, c, d, k;
    logic [5:0]  ack;
    int          n, pulses;

    vec[0]  = '{16'hA010, 16'h0064, 16'hA074, 16'h5A10, 6'b001000};
    vec[1]  = '{16'hA012, 16'h004F, 16'hA05D, 16'hE003, 6'b0};
    vec[2]  = '{16'hA011, 16'h0032, 16'h0000, 16'hE002, 6'b0};
    vec[3]  = '{16'hA001, 16'h0000, 16'hA001, 16'h5A01, 6'b100000};
    vec[4]  = '{16'hB000, 16'h1234, 16'hA234, 16'hE001, 6'b0};
    vec[5]  = '{16'hB000, 16'h1234, 16'h0000, 16'hE001, 6'b0};
    vec[6]  = '{16'hA010, 16'h0000, 16'hA010, 16'hE003, 6'b0};
    vec[7]  = '{16'hA010, 16'h03E8, 16'hA3F8, 16'h5A10, 6'b001000};
    vec[8]  = '{16'hA010, 16'h03E9, 16'hA3F9, 16'hE003, 6'b0};
    vec[9]  = '{16'hA011, 16'h2710, 16'h8701, 16'h5A11, 6'b000100};
    vec[10] = '{16'hA011, 16'h2711, 16'h8700, 16'hE003, 6'b0};
    vec[11] = '{16'hA012, 16'h004E, 16'hA05C, 16'h5A12, 6'b000010};
    vec[12] = '{16'hA013, 16'h0002, 16'hA011, 16'h5A13, 6'b000001};
    vec[13] = '{16'hA013, 16'h0003, 16'hA010, 16'hE003, 6'b0};
    vec[14] = '{16'hA002, 16'hFFFF, 16'h5FFD, 16'h5A02, 6'b010000};
    vec[15] = '{16'hA010, 16'h0000, 16'h1111, 16'hE002, 6'b0};

    rst_n    = 1'b0;
    cs_n     = 1'b1;
    rx_valid = 1'b0;
    rx_word  = '0;
    model_reset();
    repeat (3) tick();
    check("reset acks", acks, 6'b0);
    check("reset tx_load", tx_load, 1'b0);
    check("reset tx_word", tx_word, 16'h0);
    check("reset frame_error", frame_error, 1'b0);
    check_state("reset");
    rst_n = 1'b1;
    tick();
    cs_n = 1'b0;
    tick();

    // Table rows are sent back-to-back with no gap cycles.
    for (int i = 0; i < 16; i++) begin
      model_apply(vec[i].cmd, vec[i].data, vec[i].chk, tx, ack);
      run_frame($sformatf("vec%0d", i), vec[i].cmd,
                vec[i].data, vec[i].chk,
                vec[i].exp_tx, vec[i].exp_ack);
    end
    tick();
    check("pulse width tx_load", tx_load, 1'b0);
    check("pulse width acks", acks, 6'b0);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 6))
        0: begin c = 16'hA001; d = 16'($urandom); end
        1: begin c = 16'hA002; d = 16'($urandom); end
        2: begin c = 16'hA010; d = 16'($urandom_range(0, 1100)); end
        3: begin c = 16'hA011; d = 16'($urandom_range(0, 10500)); end
        4: begin c = 16'hA012; d = 16'($urandom_range(0, 90)); end
        5: begin
          c = 16'hA013;
          case ($urandom_range(0, 4))
            0: d = 16'h8000;
            1: d = 16'h0001;
            2: d = 16'h0002;
            3: d = 16'h0003;
            default: d = 16'($urandom);
          endcase
        end
        default: begin c = 16'($urandom); d = 16'($urandom); end
      endcase
      k = c ^ d;
      if ($urandom_range(0, 6) == 0)
        k = k ^ (16'h1 << $urandom_range(0, 15));
      model_apply(c, d, k, tx, ack);
      run_frame($sformatf("rnd%0d", i), c, d, k, tx, ack);
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) begin
        if (g == 0 && $urandom_range(0, 1) == 1) begin
          cs_n     = 1'b1;
          rx_valid = 1'b1;
          rx_word  = 16'($urandom);
        end
        tick();
        cs_n     = 1'b0;
        rx_valid = 1'b0;
        check($sformatf("rnd%0d gap tx_load", i), tx_load, 1'b0);
        check($sformatf("rnd%0d gap acks", i), acks, 6'b0);
      end
    end

    put_word(16'hA013);
    n = 0;
    while (!tx_load && n < 1100) begin
      tick();
      n++;
    end
    model_err();
    check("timeout seen", tx_load, 1'b1);
    check("timeout latency", (n >= 999 && n <= 1002), 1'b1);
    check_resp("timeout", 16'hE004, 6'b0);
    model_apply(16'hA013, 16'h8000, 16'h2013, tx, ack);
    run_frame("after timeout", 16'hA013, 16'h8000, 16'h2013,
              16'h5A13, 6'b000001);

    cs_n = 1'b1;
    repeat (3) tick();
    check("idle cs_n high tx_load", tx_load, 1'b0);
    cs_n = 1'b0;
    put_word(16'hA010);
    put_word(16'h0005);
    cs_n     = 1'b1;
    rx_valid = 1'b1;
    rx_word  = 16'hA015;
    tick();
    rx_valid = 1'b0;
    cs_n     = 1'b0;
    model_err();
    check_resp("abort", 16'hE005, 6'b0);
    tick();
    check("abort word dropped", tx_load, 1'b0);
    model_apply(16'hA011, 16'h0001, 16'hA010, tx, ack);
    run_frame("after abort", 16'hA011, 16'h0001, 16'hA010,
              16'h5A11, 6'b000100);

    for (int i = 0; i < 300; i++) begin
      put_word(16'hA012);
      cs_n = 1'b1;
      tick();
      cs_n = 1'b0;
      model_err();
    end
    check("saturate errcnt", error_count, 8'hFF);
    check("saturate last tx", tx_word, 16'hE005);
    check_state("saturate");

    put_word(16'hA002);
    put_word(16'h0000);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midreset acks", acks, 6'b0);
    check("midreset tx_load", tx_load, 1'b0);
    check("midreset tx_word", tx_word, 16'h0);
    check("midreset frame_error", frame_error, 1'b0);
    check_state("midreset");
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post reset tx_load", tx_load, 1'b0);
    put_word(16'hA002);
    put_word(16'h0000);
    rx_valid = 1'b1;
    rx_word  = 16'hA002;
    pulses   = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      rx_valid = 1'b0;
      if (stop_ack) pulses++;
      if (i == 0) begin
        model_apply(16'hA002, 16'h0000, 16'hA002, tx, ack);
        check_resp("stop after reset", 16'h5A02, 6'b010000);
      end
    end
    check("stop pulse count", pulses, 1);
    check("errcnt after reset", error_count, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 16'd1000: max idle cycles between words inside one frame.
REQ-002 Parameter MAX_IP, 16'd78: maximum accepted Ip value (A).
REQ-003 Parameters TON_RESET 16'd10, TOFF_RESET 16'd50, IP_RESET 16'd20, WAVEFORM_RESET 16'h0001: reset values of the data outputs.
REQ-004 Ports: clk  in  1  system clock, 100 MHz; one clock domain only.
REQ-005 Ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Ports: cs_n  in  1  SPI chip select, already synchronised; high means no frame is in progress.
REQ-007 Ports: rx_valid, rx_word  in  1, 16  one received SPI word, qualified by a single-cycle rx_valid.
REQ-008 Ports: machine_start_ack_spi, machine_stop_ack_spi  out  1 each  single-cycle command pulses.
REQ-009 Ports: change_Ton_ack/Ton_data_async, change_Toff_ack/Toff_data_async, change_Ip_ack/Ip_data_async, change_waveform_ack/waveform_data_async  out  1/16 each  single-cycle ack plus held data.
REQ-010 Ports: tx_load, tx_word  out  1, 16  response word to the SPI transmitter, qualified by tx_load.
REQ-011 Ports: frame_error  out  1  single-cycle error pulse; error_count  out  8  count of rejected frames.

Function
REQ-012 Frame format: exactly 3 words, in the order CMD, DATA, CHK; a frame is valid only when CHK == CMD ^ DATA.
REQ-013 CMD codes:
- 16'hA001 = start; 16'hA002 = stop (DATA ignored).
- 16'hA010 = Ton; 16'hA011 = Toff; 16'hA012 = Ip; 16'hA013 = waveform.
REQ-014 FSM states and transitions:
- IDLE -> GOT_CMD on an accepted word.
- GOT_CMD -> GOT_DATA on an accepted word.
- GOT_DATA -> IDLE on an accepted word, which is the CHK word.
- Whether a word is accepted is defined in REQ-015.
REQ-015 A word is accepted only when rx_valid=1 and cs_n=0; rx_valid while cs_n=1 is dropped silently.
REQ-016 Frame evaluation happens in the cycle the CHK word is accepted. Results are registered, so every ack/tx/error output appears exactly 1 cycle after that clk edge.
REQ-017 Valid frame:
- Exactly one ack pulses for 1 cycle, matching the CMD.
- The matching *_data_async output updates in the same cycle as its ack and holds until the next valid frame of the same type.
REQ-018 Range checks:
- Ton: 1..1000.
- Toff: 1..10000.
- Ip: 1..MAX_IP.
- waveform: one of 16'h8000, 16'h0001, 16'h0002.
- A violation is error code 3: no ack, and the data output is unchanged.
REQ-019 Error codes: 1 = unknown CMD, 2 = checksum mismatch, 3 = range, 4 = timeout, 5 = abort. When more than one applies, the lowest code wins.
- An unknown CMD still consumes all 3 words before it is reported.
REQ-020 Response word:
- Success: tx_load=1 with tx_word = 16'h5A00 | CMD[7:0].
- Error: tx_load=1 with tx_word = 16'hE000 | code, plus frame_error=1.
- tx_load, frame_error and the ack all occur in the same cycle.
REQ-021 Timeout:
- A 16-bit counter clears on every accepted word and counts in GOT_CMD/GOT_DATA.
- When it reaches TIMEOUT_CYCLES: error 4, FSM -> IDLE.
REQ-022 Abort:
- cs_n=1 while the FSM is in GOT_CMD/GOT_DATA gives error 5 and FSM -> IDLE.
- If that same cycle also has rx_valid=1, cs_n wins and the word is dropped.
- cs_n=1 in IDLE has no effect.
REQ-023 Back-to-back frames: a word accepted in the cycle right after a CHK word is the next CMD; no gap cycle is required.
REQ-024 error_count increments by 1 per error (codes 1-5) and saturates at 8'hFF.
REQ-025 At most one ack pulses in any cycle; acks never pulse outside a valid frame.

Reset
REQ-026 While rst_n=0:
- FSM = IDLE; timeout counter = 0.
- All acks, tx_load and frame_error = 0; tx_word = 0; error_count = 0.
- Data outputs = their *_RESET parameters.
REQ-027 Reset asserted mid-frame discards the partial frame with no error report. The first accepted word after release is treated as a CMD.

Verification
REQ-028 Words A010, 0064, A074 -> 1 cycle after CHK: change_Ton_ack=1 for 1 cycle, Ton_data_async=100, tx_word=5A10.
REQ-029 Words A012, 004F, A05D (Ip=79 > MAX_IP) -> no ack, Ip_data_async still 20, tx_word=E003, frame_error=1, error_count=1.
REQ-030 Words A011, 0032, 0000 -> tx_word=E002, no ack. A following back-to-back valid frame A001, 0000, A001 -> machine_start_ack_spi=1, tx_word=5A01.
REQ-031 Word A013, then no word for 1000 cycles -> tx_word=E004. A later frame A013, 8000, 2013 -> waveform_data_async=8000.
REQ-032 Words A010, 0005, then cs_n=1 together with rx_valid -> tx_word=E005, word dropped. 300 forced errors -> error_count=FF.
REQ-033 rst_n=0 after 2 words of a frame -> all outputs at reset values. After release, A002, 0000, A002 -> machine_stop_ack_spi=1 exactly once.
